vga_draw_ctrl: RTL and testbench
================================

VGA_DRAW_CTRL -- requirements
Module: vga_draw_ctrl

Interface
REQ-001 Parameter: SCREEN_W, 320, visible width in pixels; x range 0..SCREEN_W-1.
REQ-002 Parameter: SCREEN_H, 240, visible height in pixels; y range 0..SCREEN_H-1.
REQ-003 Parameter: BG_COLOR, 3'b000, colour used by the clear command.
REQ-004 Ports SHALL be, one per line: name  direction  width  meaning (clock and reset first).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  block can accept a command; accept = cmd_valid & cmd_ready at a rising edge.
REQ-009 cmd_op  in  1  0 = fill rectangle, 1 = clear screen.
REQ-010 cmd_x0  in  9  rectangle left x.
REQ-011 cmd_y0  in  8  rectangle top y.
REQ-012 cmd_w  in  9  rectangle width in pixels.
REQ-013 cmd_h  in  8  rectangle height in pixels.
REQ-014 cmd_color  in  3  fill colour {R,G,B}.
REQ-015 abort  in  1  terminate the current command.
REQ-016 vga_x  out  9  pixel x to the VGA adapter.
REQ-017 vga_y  out  8  pixel y to the VGA adapter.
REQ-018 vga_color  out  3  pixel colour to the VGA adapter.
REQ-019 vga_plot  out  1  write enable to the VGA adapter; one pixel per high cycle.
REQ-020 busy  out  1  high while a command is in progress (states DRAW, DONE).
REQ-021 done  out  1  one-cycle pulse at command completion or abort.

Function
REQ-022 FSM states SHALL be IDLE, DRAW, DONE; cmd_ready = (state == IDLE).
REQ-023 On accept, cmd_op/cmd_x0/cmd_y0/cmd_w/cmd_h/cmd_color SHALL be latched; later input changes have no effect.
REQ-024 Clear (cmd_op=1) SHALL behave as a fill with x0=0, y0=0, w=SCREEN_W, h=SCREEN_H, colour=BG_COLOR, ignoring the other command fields.
REQ-025 If latched w==0 or h==0, state SHALL go IDLE->DONE; no vga_plot is asserted.
REQ-026 Otherwise, state SHALL go IDLE->DRAW at the accept edge, with vga_x=x0, vga_y=y0, vga_color=colour registered on that same edge (first pixel visible the cycle after accept).
REQ-027 In DRAW, each edge SHALL advance one pixel in raster order: column offset increments; at offset w-1 it wraps to 0 and the row offset increments.
REQ-028 The rectangle SHALL occupy exactly w*h DRAW cycles; after the pixel at (w-1, h-1) the next edge SHALL enter DONE.
REQ-029 Pixel address arithmetic SHALL be at least 10 bits (x0+col, y0+row) so that overflow is detected rather than wrapped.
REQ-030 vga_plot SHALL be high in a DRAW cycle only if x0+col < SCREEN_W and y0+row < SCREEN_H; clipped pixels still consume their cycle with vga_plot low.
REQ-031 vga_plot SHALL be low in IDLE and DONE.
REQ-032 DONE SHALL last exactly one cycle, with done=1; the next state is IDLE.
REQ-033 abort high at an edge in DRAW SHALL force DONE (vga_plot low next cycle); abort in IDLE or DONE SHALL be ignored.
REQ-034 Commands SHALL NOT queue; cmd_valid while not in IDLE is held off via cmd_ready=0.

Reset
REQ-035 While rst=0 at an edge: state=IDLE, vga_x=0, vga_y=0, vga_color=0, vga_plot=0, busy=0, done=0, and all counters/latches are 0.
REQ-036 Reset during DRAW SHALL discard the command with no further plots; cmd_ready=1 on the first cycle after release.

Verification
REQ-037 Reset -> all outputs 0 and cmd_ready=1 after release.
REQ-038 Fill x0=10, y0=20, w=2, h=2, colour=3'b100 -> plots (10,20),(11,20),(10,21),(11,21) on 4 consecutive cycles; done pulses 1 cycle later; cmd_ready returns the following cycle.
REQ-039 Fill x0=318, y0=239, w=4, h=2 -> 8 DRAW cycles; vga_plot high only for (318,239) and (319,239).
REQ-040 Fill with w=0 -> zero plots; done one cycle after accept.
REQ-041 Clear with BG_COLOR=3'b000 -> 76800 consecutive plots from (0,0) to (319,239), colour 000, then done.
REQ-042 Abort on the 3rd DRAW cycle of a 10x10 fill, and separately rst=0 mid-fill -> no plots after that edge; abort gives a done pulse, reset gives none; a new command is accepted afterward.

Source files
------------

// File: rtl/vga_draw_ctrl.sv
// Rectangle fill / screen clear engine for a VGA pixel-write adapter.
// Streams one pixel per cycle in raster order and clips pixels that fall off-screen.
module vga_draw_ctrl #(
    parameter int         SCREEN_W = 320,
    parameter int         SCREEN_H = 240,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [8:0] cmd_x0,
    input  logic [7:0] cmd_y0,
    input  logic [8:0] cmd_w,
    input  logic [7:0] cmd_h,
    input  logic [2:0] cmd_color,
    input  logic       abort,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t     state, state_n;
    logic [8:0] x0_q, x0_n, w_q, w_n, col_q, col_n;
    logic [7:0] y0_q, y0_n, h_q, h_n, row_q, row_n;
    logic [2:0] color_q, color_n;
    logic [8:0] vx_n;
    logic [7:0] vy_n;
    logic [2:0] vc_n;
    logic       plot_n;

    logic       accept, col_last, row_last;
    logic [8:0] sel_x0, sel_w, base_x;
    logic [7:0] sel_y0, sel_h, base_y;
    logic [2:0] sel_color;
    logic [9:0] addr_x, addr_y;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = cmd_valid & cmd_ready;

    // Clear is just a full-screen fill in the background colour
    assign sel_x0    = cmd_op ? 9'd0 : cmd_x0;
    assign sel_y0    = cmd_op ? 8'd0 : cmd_y0;
    assign sel_w     = cmd_op ? 9'(SCREEN_W) : cmd_w;
    assign sel_h     = cmd_op ? 8'(SCREEN_H) : cmd_h;
    assign sel_color = cmd_op ? BG_COLOR : cmd_color;

    assign col_last  = (col_q == w_q - 9'd1);
    assign row_last  = (row_q == h_q - 8'd1);

    // 10-bit sums so an off-screen pixel is detected instead of wrapping back on-screen
    assign addr_x = {1'b0, base_x} + {1'b0, col_n};
    assign addr_y = {2'b00, base_y} + {2'b00, row_n};

    always_comb begin
        state_n = state;
        x0_n    = x0_q;
        y0_n    = y0_q;
        w_n     = w_q;
        h_n     = h_q;
        color_n = color_q;
        col_n   = col_q;
        row_n   = row_q;
        base_x  = x0_q;
        base_y  = y0_q;
        vx_n    = vga_x;
        vy_n    = vga_y;
        vc_n    = vga_color;
        plot_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    x0_n    = sel_x0;
                    y0_n    = sel_y0;
                    w_n     = sel_w;
                    h_n     = sel_h;
                    color_n = sel_color;
                    col_n   = 9'd0;
                    row_n   = 8'd0;
                    base_x  = sel_x0;
                    base_y  = sel_y0;
                    if (sel_w == 9'd0 || sel_h == 8'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n = DRAW;
                        vx_n    = addr_x[8:0];
                        vy_n    = addr_y[7:0];
                        vc_n    = sel_color;
                        plot_n  = (addr_x < 10'(SCREEN_W)) && (addr_y < 10'(SCREEN_H));
                    end
                end
            end
            DRAW: begin
                if (abort || (col_last && row_last)) begin
                    state_n = DONE;
                end else begin
                    if (col_last) begin
                        col_n = 9'd0;
                        row_n = row_q + 8'd1;
                    end else begin
                        col_n = col_q + 9'd1;
                    end
                    vx_n   = addr_x[8:0];
                    vy_n   = addr_y[7:0];
                    vc_n   = color_q;
                    plot_n = (addr_x < 10'(SCREEN_W)) && (addr_y < 10'(SCREEN_H));
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            x0_q      <= x0_n;
            y0_q      <= y0_n;
            w_q       <= w_n;
            h_q       <= h_n;
            color_q   <= color_n;
            col_q     <= col_n;
            row_q     <= row_n;
            vga_x     <= vx_n;
            vga_y     <= vy_n;
            vga_color <= vc_n;
            vga_plot  <= plot_n;
        end
    end

endmodule

// File: tb/tb_vga_draw_ctrl.sv
// Self-checking bench for vga_draw_ctrl: command table, per-cycle expected trace
// in a scoreboard queue, plus hand-written reset-mid-draw sequence.
module tb_vga_draw_ctrl;

    localparam int SW = 320;
    localparam int SH = 240;
    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_op, abort;
    logic [8:0] cmd_x0, cmd_w, vga_x;
    logic [7:0] cmd_y0, cmd_h, vga_y;
    logic [2:0] cmd_color, vga_color;
    logic       vga_plot, busy, done;

    vga_draw_ctrl #(.SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .abort(abort),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op, x0, y0, w, h, color;
        int abort_at;   // -1 none, 0 asserted on the accept edge, k on the k-th DRAW cycle
        int exp_plots;
    } vec_t;

    typedef struct {
        logic       ready, bsy, dn, plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent model: pixel i of a w*h raster is (x0 + i%w, y0 + i/w)
    task automatic build_trace(input vec_t v);
        int ex0, ey0, ew, eh, n, ncyc, px, py;
        logic [2:0] ec;
        exp_t e;
        ex0 = v.op ? 0 : v.x0;
        ey0 = v.op ? 0 : v.y0;
        ew  = v.op ? SW : v.w;
        eh  = v.op ? SH : v.h;
        ec  = v.op ? BG : 3'(v.color);
        n   = ew * eh;
        ncyc = (v.abort_at > 0 && v.abort_at < n) ? v.abort_at : n;
        for (int i = 0; i < ncyc; i++) begin
            px = ex0 + i % ew;
            py = ey0 + i / ew;
            e.ready = 1'b0; e.bsy = 1'b1; e.dn = 1'b0;
            e.plot  = (px < SW) && (py < SH);
            e.x = 9'(px); e.y = 8'(py); e.c = ec;
            sb.push_back(e);
        end
        e.ready = 1'b0; e.bsy = 1'b1; e.dn = 1'b1; e.plot = 1'b0;
        e.x = '0; e.y = '0; e.c = '0;
        sb.push_back(e);
    endtask

    task automatic run(input vec_t v, input string name);
        exp_t e;
        logic [23:0] act, expv, mask;
        int cyc, plots;
        build_trace(v);
        @(negedge clk);
        chk({name, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_op = v.op[0]; cmd_x0 = 9'(v.x0); cmd_y0 = 8'(v.y0);
        cmd_w = 9'(v.w); cmd_h = 8'(v.h); cmd_color = 3'(v.color);
        cmd_valid = 1'b1;
        abort = (v.abort_at == 0);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        // keep requesting with scrambled fields: must be neither latched nor queued
        cmd_op = ~cmd_op; cmd_x0 = 9'($urandom); cmd_y0 = 8'($urandom);
        cmd_w = 9'($urandom); cmd_h = 8'($urandom); cmd_color = 3'($urandom);
        cyc = 1; plots = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dn) cmd_valid = 1'b0;
            act  = {cmd_ready, busy, done, vga_plot, vga_x, vga_y, vga_color};
            expv = {e.ready, e.bsy, e.dn, e.plot, e.x, e.y, e.c};
            mask = e.plot ? 24'hFFFFFF : 24'hF00000;
            chk({name, "_cycle"}, 32'(act & mask), 32'(expv & mask));
            if (vga_plot) plots++;
            abort = (cyc == v.abort_at);
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b0;
        chk({name, "_back_idle"}, {28'd0, cmd_ready, busy, done, vga_plot}, 32'b1000);
        chk({name, "_plot_count"}, 32'(plots), 32'(v.exp_plots));
    endtask

    vec_t tbl[12];

    initial begin
        //          op  x0   y0   w    h    col abort plots
        tbl[0]  = '{0,  10,  20,  2,   2,   4,  -1,   4};
        tbl[1]  = '{0,  318, 239, 4,   2,   2,  -1,   2};
        tbl[2]  = '{0,  5,   5,   0,   3,   1,  -1,   0};
        tbl[3]  = '{0,  5,   5,   3,   0,   1,  -1,   0};
        tbl[4]  = '{0,  0,   0,   1,   1,   7,  -1,   1};
        tbl[5]  = '{0,  400, 10,  2,   2,   1,  -1,   0};
        tbl[6]  = '{0,  5,   238, 1,   5,   3,  -1,   2};
        tbl[7]  = '{0,  500, 0,   20,  1,   5,  -1,   0};
        tbl[8]  = '{0,  310, 230, 20,  20,  6,  -1,   100};
        tbl[9]  = '{0,  50,  60,  10,  10,  5,   3,   3};
        tbl[10] = '{0,  7,   7,   2,   1,   6,   0,   2};
        tbl[11] = '{1,  100, 5,   5,   5,   7,  -1,   76800};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; abort = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {8'd0, busy, done, vga_plot, vga_x, vga_y, vga_color}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", {29'd0, cmd_ready, busy, done}, 32'b100);

        for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a 10x10 fill: no further plots, no done pulse
        @(negedge clk);
        cmd_op = 1'b0; cmd_x0 = 9'd100; cmd_y0 = 8'd100; cmd_w = 9'd10; cmd_h = 8'd10;
        cmd_color = 3'd3; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("pre_rst_pixel", {12'd0, vga_plot, vga_x, vga_y, vga_color},
            {12'd0, 1'b1, 9'd103, 8'd100, 3'd3});
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", {7'd0, cmd_ready, busy, done, vga_plot, vga_x, vga_y, vga_color},
            {7'd0, 1'b1, 23'd0});
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_quiet", {28'd0, cmd_ready, busy, done, vga_plot}, 32'b1000);
        end
        run(tbl[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
